mem_access_ctrl: RTL

- Sequences the MEM stage between the EXE/MEM pipeline register and a multi-cycle data memory with a req/ack handshake.
- Issues one memory transaction per load or store and holds `freeze` high so every pipeline register stalls until the access completes.
- Captures read data for the MEM/WB register.
- Aborts hung accesses after a programmable timeout.

---
 rtl/mem_access_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage sequencer between the EXE/MEM register and a
// multi-cycle data memory using a req/ack handshake. One transaction per
// load/store; freeze stalls the whole pipeline until the access finishes.
// Hung accesses are aborted after TIMEOUT cycles.
// Optional: define MEM_STALL_CNT_EN to add stall_cnt / access_cnt counters.
//
// state | meaning
// IDLE  | no access in flight; issues on mem_r_en | mem_w_en
// REQ   | mem_req held, waiting for mem_ack or timeout
// DONE  | access finished, pipeline advances; enables here are ignored

module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] alu_res,
  input  logic [DATA_W-1:0] st_val,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              freeze,
  output logic [DATA_W-1:0] rd_data,
  output logic              timeout_err,
  output logic              proto_err
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       access_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Last counter value before abort; TIMEOUT is limited to 1..255.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       issue;

  // New access is accepted only from IDLE, so the frozen instruction still
  // presenting its enables in DONE cannot start a second transaction.
  always_comb begin
    issue = (state == IDLE) && (mem_r_en || mem_w_en);
  end

  // Freeze is combinational so the issue cycle itself already stalls.
  always_comb begin
    freeze = (state == REQ) || issue;
  end

  // Handshake FSM, request/address/data registers and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rd_data     <= '0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            mem_addr  <= alu_res;
            mem_wdata <= st_val;
            // Both enables high is illegal; the write wins.
            mem_we    <= mem_w_en;
            mem_req   <= 1'b1;
            cnt       <= '0;
            proto_err <= mem_r_en && mem_w_en;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            // Ack beats a simultaneous timeout.
            mem_req <= 1'b0;
            if (!mem_we) begin
              rd_data <= mem_rdata;
            end
            state <= DONE;
          end else if (cnt == TO_LAST) begin
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_STALL_CNT_EN
  // Saturating stall-cycle and access counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      access_cnt <= '0;
    end else begin
      if (freeze && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (issue && (access_cnt != '1)) begin
        access_cnt <= access_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
